// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller: state encoding,
// coin codes and the coin-code to credit-unit conversion.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_ZERO = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Invalid codes are worth nothing but are still consumed.
    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_ONE: return 2'd1;
            COIN_TWO: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// Two-requester round-robin arbiter; the pointer names the preferred
// requester and flips only when both requested in the same cycle.
module vend_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= 1'b0;
        else if (&req)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/vend_sequencer.sv
// Purchase controller: coin arbitration into a shared credit register,
// per-product stock, dispense sequencing and unit-by-unit change return.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NPROD      = 4,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int STOCK_INIT = 8,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int SEL_W      = $clog2(NPROD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_a_valid,
    input  logic [1:0]          coin_a,
    output logic                coin_a_ready,
    input  logic                coin_b_valid,
    input  logic [1:0]          coin_b,
    output logic                coin_b_ready,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_id,
    output logic                change_pulse,
    output logic                sel_err,
    output logic [CREDIT_W-1:0] credit,
    output logic [NPROD-1:0]    sold_out,
    output logic                busy
);

    state_t              state;
    logic [STOCK_W-1:0]  stock [NPROD];

    logic                coin_en;
    logic [1:0]          val_a, val_b, coin_val;
    logic [CREDIT_W:0]   sum_a, sum_b;
    logic [1:0]          req, grant;
    logic [CREDIT_W-1:0] credit_add;
    logic                sel_ok;

    // Coins are only taken when no control request competes for the cycle.
    assign coin_en = (state == S_IDLE || state == S_COLLECT) && !cancel && !sel_valid;

    assign val_a = coin_value(coin_a);
    assign val_b = coin_value(coin_b);
    assign sum_a = {1'b0, credit} + (CREDIT_W + 1)'(val_a);
    assign sum_b = {1'b0, credit} + (CREDIT_W + 1)'(val_b);

    // A coin that would overflow the ceiling is held, never dropped.
    assign req[0] = coin_en && coin_a_valid && (sum_a <= (CREDIT_W + 1)'(MAX_CREDIT));
    assign req[1] = coin_en && coin_b_valid && (sum_b <= (CREDIT_W + 1)'(MAX_CREDIT));

    vend_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign coin_a_ready = grant[0];
    assign coin_b_ready = grant[1];
    assign coin_val     = grant[0] ? val_a : (grant[1] ? val_b : 2'd0);
    assign credit_add   = credit + CREDIT_W'(coin_val);

    assign sel_ok = (credit >= CREDIT_W'(PRICE)) && (stock[sel] != '0);
    assign busy   = (state == S_VEND) || (state == S_REFUND);

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NPROD; i++)
            sold_out[i] = (stock[i] == '0);
    end

    // NOTE: the stock array is architectural state, so it is reset like any
    // other register rather than left to power-up contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            credit       <= '0;
            dispense     <= 1'b0;
            dispense_id  <= '0;
            change_pulse <= 1'b0;
            sel_err      <= 1'b0;
            for (int i = 0; i < NPROD; i++)
                stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            dispense     <= 1'b0;
            change_pulse <= 1'b0;
            sel_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_valid)
                        sel_err <= 1'b1;
                    if (restock)
                        for (int i = 0; i < NPROD; i++)
                            stock[i] <= STOCK_W'(STOCK_INIT);
                    if (|grant) begin
                        credit <= credit_add;
                        if (coin_val != 2'd0)
                            state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        state        <= S_REFUND;
                        change_pulse <= 1'b1;
                    end else if (sel_valid) begin
                        if (sel_ok) begin
                            credit      <= credit - CREDIT_W'(PRICE);
                            stock[sel]  <= stock[sel] - STOCK_W'(1);
                            dispense_id <= sel;
                            dispense    <= 1'b1;
                            state       <= S_VEND;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end else if (|grant) begin
                        credit <= credit_add;
                    end
                end
                S_VEND: begin
                    if (credit != '0) begin
                        state        <= S_REFUND;
                        change_pulse <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_REFUND: begin
                    // The pulse stays high for every cycle spent in REFUND.
                    if (credit <= CREDIT_W'(1)) begin
                        credit <= '0;
                        state  <= S_IDLE;
                    end else begin
                        credit       <= credit - CREDIT_W'(1);
                        change_pulse <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Transaction controller sitting in front of the vending datapath: arbitrates coin entry from two coin acceptors into a shared credit register, tracks per-product stock, and sequences product dispense followed by unit-by-unit change return. It owns credit, stock and the purchase state machine; the coin acceptors, selection keypad and dispense/change actuators sit on its ports.

## Interface
- NPROD, 4, number of products; select index width is 2
- PRICE, 3, price of every product in credit units
- MAX_CREDIT, 7, credit ceiling; coins that would exceed it are held off
- STOCK_INIT, 8, per-product stock after reset or restock
- CREDIT_W, 4, credit register width
- STOCK_W, 4, per-product stock counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coin_a_valid  in  1  acceptor A presents a coin
- coin_a  in  2  coin code A: 00 = 0, 01 = 1 unit, 10 = 2 units, 11 = invalid
- coin_a_ready  out  1  coin A consumed this cycle (combinational)
- coin_b_valid / coin_b / coin_b_ready: same as A, for acceptor B
- sel_valid  in  1  product selection request
- sel  in  2  product index
- cancel  in  1  abort purchase, refund credit
- restock  in  1  reload all stock to STOCK_INIT
- dispense  out  1  one-cycle product release pulse (registered)
- dispense_id  out  2  product index, valid while dispense=1
- change_pulse  out  1  one credit unit returned per cycle high (registered)
- sel_err  out  1  one-cycle pulse: selection rejected
- credit  out  CREDIT_W  current credit
- sold_out  out  NPROD  bit i high when stock[i]==0
- busy  out  1  high in VEND or REFUND

## Operation
- States: IDLE (credit==0), COLLECT (credit>0), VEND, REFUND.
- Coin acceptance only in IDLE/COLLECT, only when cancel=0 and sel_valid=0 that cycle.
- Coin value: 00 → 0, 01 → 1, 10 → 2, 11 → 0 (consumed and discarded).
- A coin is grantable only if credit+value <= MAX_CREDIT; an ungrantable coin is held (ready=0), not dropped.
- Two-way round-robin arbiter: when both acceptors are grantable, grant the one not granted most recently; pointer resets to A and flips only on a contested grant. One coin per cycle at most.
- IDLE → COLLECT on acceptance of any nonzero coin.
- Priority within COLLECT: cancel > sel_valid > coin.
- cancel in COLLECT → REFUND. cancel in IDLE/VEND/REFUND is ignored.
- sel_valid in COLLECT: accepted if credit>=PRICE and stock[sel]>0 → VEND; otherwise sel_err pulses next cycle, state and credit unchanged. sel_valid in IDLE also produces sel_err.
- On selection acceptance: credit -= PRICE, stock[sel] -= 1, dispense_id latched.
- VEND (one cycle): dispense=1; next state REFUND if credit>0, else IDLE.
- REFUND: change_pulse=1 every cycle; credit decrements by 1 per edge; exits to IDLE on the edge where credit goes 1→0. Credit N yields exactly N pulses.
- restock honoured only in IDLE; ignored elsewhere.
- Stock never decrements below 0; credit never exceeds MAX_CREDIT.

## Timing
- Reset (rst=0, async): state IDLE, credit 0, every stock = STOCK_INIT, arbiter pointer A, all outputs 0 (sold_out=0 when STOCK_INIT>0).
- Reset mid-VEND/REFUND aborts immediately; the pending dispense/change is lost.
- Coin handshake: consumed at the edge with valid&&ready; credit reflects it the following cycle.
- Selection at edge t → dispense=1 in cycle t+1; first change_pulse in t+2 if credit remains.
- sel_err: one cycle, in the cycle following the rejected request.
- Throughput: one coin per cycle; back-to-back purchases need ≥1 COLLECT cycle between them.

## Structure
- Shared package vend_pkg: state encoding, coin-code constants and coin-value function.
- Sub-module vend_rr_arb: two-requester round-robin arbiter (req[1:0], grant[1:0], pointer flop).
- Stock: NPROD counters in one array; sold_out is a combinational decode of it.

## Test plan
- Reset, coin_a=01 on three consecutive cycles, sel=2 → credit 1,2,3; dispense=1 with dispense_id=2; stock[2]=7; no change pulses; back to IDLE.
- Both acceptors valid with 10 every cycle from IDLE → grants alternate A,B (credit 2,4,6); coin at credit 6 held off (ready=0) until a purchase.
- Credit 7, sel=0 → dispense, then exactly 4 change_pulse cycles, credit 0, IDLE.
- Credit 2, sel=1 → sel_err pulse, credit stays 2; cancel → 2 change pulses; cancel and sel_valid in same cycle → refund wins.
- Buy product 3 eight times → sold_out[3]=1; ninth attempt → sel_err, credit retained; restock in IDLE → sold_out=0.
- Assert rst during REFUND at credit 3 → outputs 0, credit 0, stock unchanged from STOCK_INIT reload, IDLE.
